// File: rtl/rx78_gfx_pkg.sv
// Shared colour decode, intensity levels and default geometry for the RX-78
// pixel pipeline.
package rx78_gfx_pkg;

  localparam logic [7:0] INT_LO = 8'h7f;
  localparam logic [7:0] INT_HI = 8'hff;

  localparam int DEF_PLANES    = 3;
  localparam int DEF_H_ACTIVE  = 192;
  localparam int DEF_V_ACTIVE  = 184;
  localparam int DEF_BORDER_X  = 32;
  localparam int DEF_BORDER_Y  = 20;
  localparam int DEF_VRAM_BASE = 'hec0;
  localparam int DEF_STRIDE    = 24;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_ISSUE = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // One channel: enable bit selects on/off, intensity bit selects full or half.
  function automatic logic [7:0] chan_level(input logic on, input logic hi);
    if (!on) return 8'h00;
    return hi ? INT_HI : INT_LO;
  endfunction

  // Colour byte layout: [6:4] channel enables B/G/R, [2:0] intensities B/G/R.
  function automatic rgb_t decode_rgb(input logic [7:0] cr);
    rgb_t o;
    logic unused_cr;
    unused_cr = cr[7] ^ cr[3];
    o.r = chan_level(cr[4], cr[0]);
    o.g = chan_level(cr[5], cr[1]);
    o.b = chan_level(cr[6], cr[2]);
    return o;
  endfunction

  // Colour mask only takes effect when it leaves something behind.
  function automatic logic [7:0] apply_cmask(input logic [7:0] c, input logic [7:0] cmask);
    logic [7:0] cm;
    cm = c & cmask;
    return (cm != 8'h00) ? cm : c;
  endfunction

endpackage

// File: rtl/rx78_plane_fetch.sv
// Column fetch engine: reads one byte per plane for the next 8-pixel column
// and parks the bytes in per-plane holding registers.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// FETCH_IDLE  | waiting for a column trigger
// FETCH_ISSUE | one read per cycle, planes 0..2*PLANES-1, cnt counts down
// FETCH_DRAIN | no read issued; last plane's byte returns this cycle
module rx78_plane_fetch
  import rx78_gfx_pkg::*;
#(
  parameter int PLANES    = DEF_PLANES,
  parameter int VRAM_BASE = DEF_VRAM_BASE,
  parameter int STRIDE    = DEF_STRIDE
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    trigger,
  input  logic [8:0]              row,
  input  logic [7:0]              col,
  output logic                    busy,
  output logic                    vram_rd,
  output logic [2:0]              vram_plane,
  output logic [12:0]             vram_addr,
  input  logic [7:0]              vram_data,
  output logic [8*2*PLANES-1:0]   hold
);

  localparam int NPL = 2 * PLANES;
  localparam logic [2:0] LAST_CNT = 3'(NPL - 1);

  fetch_state_e state, state_nxt;
  logic [2:0]   cnt;
  logic         rd_d;
  logic [2:0]   plane_d;
  logic [12:0]  addr_calc;

  // Row/column address wraps naturally at 13 bits.
  assign addr_calc = 13'(VRAM_BASE) + 13'(row) * 13'(STRIDE) + 13'(col);

  assign vram_rd = (state == FETCH_ISSUE);
  assign busy    = (state != FETCH_IDLE);

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= FETCH_IDLE;
    else          state <= state_nxt;
  end

  // Next-state: a trigger while busy is dropped on purpose.
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_IDLE:  if (trigger) state_nxt = FETCH_ISSUE;
      FETCH_ISSUE: if (cnt == 3'd0) state_nxt = FETCH_DRAIN;
      FETCH_DRAIN: state_nxt = FETCH_IDLE;
      default:     state_nxt = FETCH_IDLE;
    endcase
  end

  // Read sequencing: latch the column address, then step plane index while cnt runs down.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= 3'd0;
      vram_plane <= 3'd0;
      vram_addr  <= 13'd0;
    end else if (state == FETCH_IDLE && trigger) begin
      cnt        <= LAST_CNT;
      vram_plane <= 3'd0;
      vram_addr  <= addr_calc;
    end else if (state == FETCH_ISSUE && cnt != 3'd0) begin
      cnt        <= cnt - 3'd1;
      vram_plane <= vram_plane + 3'd1;
    end
  end

  // Capture: data lags the strobe by one cycle, so remember which plane was asked for.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rd_d    <= 1'b0;
      plane_d <= 3'd0;
      hold    <= '0;
    end else begin
      rd_d    <= vram_rd;
      plane_d <= vram_plane;
      if (rd_d) begin
        for (int i = 0; i < NPL; i++) begin
          if (plane_d == 3'(i)) hold[8*i +: 8] <= vram_data;
        end
      end
    end
  end

endmodule

// File: rtl/rx78_pixel_pipe.sv
// RX-78 pixel pipeline: window/border decode, column prefetch control,
// per-plane shift registers, fg/bg/backdrop priority and output registers.
module rx78_pixel_pipe
  import rx78_gfx_pkg::*;
#(
  parameter int PLANES    = DEF_PLANES,
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int BORDER_X  = DEF_BORDER_X,
  parameter int BORDER_Y  = DEF_BORDER_Y,
  parameter int VRAM_BASE = DEF_VRAM_BASE,
  parameter int STRIDE    = DEF_STRIDE
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  ce_pix,
  input  logic [8:0]            h,
  input  logic [8:0]            v,
  input  logic                  de_in,
  output logic                  vram_rd,
  output logic [2:0]            vram_plane,
  output logic [12:0]           vram_addr,
  input  logic [7:0]            vram_data,
  input  logic [7:0]            mask,
  input  logic [8*2*PLANES-1:0] pal,
  input  logic [7:0]            cmask,
  input  logic [7:0]            bgc,
  output logic [7:0]            red,
  output logic [7:0]            green,
  output logic [7:0]            blue,
  output logic                  de_out,
  output logic                  underrun
);

  localparam int NPL = 2 * PLANES;
  localparam logic signed [10:0] BX_S       = 11'(BORDER_X);
  localparam logic signed [10:0] BY_S       = 11'(BORDER_Y);
  localparam logic signed [10:0] HA_S       = 11'(H_ACTIVE);
  localparam logic signed [10:0] VA_S       = 11'(V_ACTIVE);
  localparam logic signed [10:0] FIRST_TRIG = -11'sd8;
  localparam logic signed [10:0] LAST_TRIG  = 11'(H_ACTIVE - 16);

  logic signed [10:0]  x, y, col_s;
  logic                act_x, act_y, active;
  logic                trigger, col_load, busy;
  logic [8*NPL-1:0]    hold, sr;
  logic [7:0]          c_fg, c_bg;
  rgb_t                rgb_fg, rgb_bg, rgb_bgc, pix_rgb;
  logic                unused_bits;

  assign x = $signed({2'b00, h}) - BX_S;
  assign y = $signed({2'b00, v}) - BY_S;

  assign act_x  = !x[10] && (x < HA_S);
  assign act_y  = !y[10] && (y < VA_S);
  assign active = act_x && act_y;

  // Fetch one column ahead: x = -8 fetches column 0, last fetch at H_ACTIVE-16.
  assign col_s   = (x >>> 3) + 11'sd1;
  assign trigger = ce_pix && act_y && (x[2:0] == 3'd0) && (x >= FIRST_TRIG) && (x <= LAST_TRIG);

  // x == -1 also has low bits 7, so one compare covers the column-0 load too.
  assign col_load = ce_pix && (x[2:0] == 3'd7);

  assign unused_bits = ^{mask, col_s[10:8], y[10:9]};

  rx78_plane_fetch #(
    .PLANES    (PLANES),
    .VRAM_BASE (VRAM_BASE),
    .STRIDE    (STRIDE)
  ) u_fetch (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .trigger    (trigger),
    .row        (y[8:0]),
    .col        (col_s[7:0]),
    .busy       (busy),
    .vram_rd    (vram_rd),
    .vram_plane (vram_plane),
    .vram_addr  (vram_addr),
    .vram_data  (vram_data),
    .hold       (hold)
  );

  // Sticky underrun: a column load while the fetch is still running.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                underrun <= 1'b0;
    else if (col_load && busy)   underrun <= 1'b1;
  end

  // Shift registers: load a column, else shift right per active pixel (LSB is leftmost).
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sr <= '0;
    end else if (col_load) begin
      sr <= hold;
    end else if (ce_pix && active) begin
      for (int i = 0; i < NPL; i++) sr[8*i +: 8] <= {1'b0, sr[8*i+1 +: 7]};
    end
  end

  assign rgb_bgc = decode_rgb(bgc);

  // Layer colours and priority; "black" means the red channel is off.
  always_comb begin
    c_fg    = 8'h00;
    c_bg    = 8'h00;
    for (int i = 0; i < NPL; i++) begin
      if (mask[i] && sr[8*i]) begin
        if (i < PLANES) c_fg = c_fg | pal[8*i +: 8];
        else            c_bg = c_bg | pal[8*i +: 8];
      end
    end
    rgb_fg  = decode_rgb(apply_cmask(c_fg, cmask));
    rgb_bg  = decode_rgb(apply_cmask(c_bg, cmask));
    pix_rgb = rgb_bgc;
    if (rgb_fg.r != 8'h00)      pix_rgb = rgb_fg;
    else if (rgb_bg.r != 8'h00) pix_rgb = rgb_bg;
  end

  // Output registers update once per pixel and hold between pulses.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      red    <= 8'h00;
      green  <= 8'h00;
      blue   <= 8'h00;
      de_out <= 1'b0;
    end else if (ce_pix) begin
      de_out <= de_in;
      if (!de_in)      {red, green, blue} <= 24'h000000;
      else if (active) {red, green, blue} <= pix_rgb;
      else             {red, green, blue} <= rgb_bgc;
    end
  end

endmodule

// File: tb/tb_rx78_pixel_pipe.sv
// Randomized raster bench for rx78_pixel_pipe against a per-pixel
// behavioural model that reads the VRAM image directly.
module tb_rx78_pixel_pipe;

  localparam int P   = 3;
  localparam int NPL = 2 * P;
  localparam int HA  = 192;
  localparam int VA  = 184;
  localparam int BX  = 32;
  localparam int BY  = 20;
  localparam int VB  = 'hec0;
  localparam int ST  = 24;
  localparam int NDIR = 7;

  logic             clk_sys = 1'b0;
  logic             reset_n = 1'b0;
  logic             ce_pix  = 1'b0;
  logic [8:0]       h = 9'd0;
  logic [8:0]       v = 9'd0;
  logic             de_in = 1'b0;
  logic             vram_rd;
  logic [2:0]       vram_plane;
  logic [12:0]      vram_addr;
  logic [7:0]       vram_data = 8'h00;
  logic [7:0]       mask  = 8'h00;
  logic [8*NPL-1:0] pal   = '0;
  logic [7:0]       cmask = 8'h00;
  logic [7:0]       bgc   = 8'h00;
  logic [7:0]       red, green, blue;
  logic             de_out, underrun;

  logic [7:0] mem [NPL][8192];
  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt  = 0;

  logic [7:0]  dir_mask [NDIR];
  logic [7:0]  dir_fg   [NDIR];
  logic [7:0]  dir_bg   [NDIR];
  logic [7:0]  dir_cm   [NDIR];
  logic [7:0]  dir_bgc  [NDIR];
  logic [23:0] dir_rgb  [NDIR];

  rx78_pixel_pipe #(
    .PLANES(P), .H_ACTIVE(HA), .V_ACTIVE(VA), .BORDER_X(BX), .BORDER_Y(BY),
    .VRAM_BASE(VB), .STRIDE(ST)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix), .h(h), .v(v), .de_in(de_in),
    .vram_rd(vram_rd), .vram_plane(vram_plane), .vram_addr(vram_addr), .vram_data(vram_data),
    .mask(mask), .pal(pal), .cmask(cmask), .bgc(bgc),
    .red(red), .green(green), .blue(blue), .de_out(de_out), .underrun(underrun)
  );

  always #5 clk_sys = ~clk_sys;

  // VRAM: one-cycle read latency; also counts strobes.
  always @(posedge clk_sys) begin
    if (vram_rd) begin
      vram_data <= mem[vram_plane][vram_addr];
      rd_cnt    <= rd_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, want);
    end
  endtask

  function automatic logic [7:0] m_chan(input logic [7:0] cr, input int k);
    if (!cr[4+k]) return 8'h00;
    return cr[k] ? 8'hff : 8'h7f;
  endfunction

  function automatic logic [23:0] m_rgb(input logic [7:0] cr);
    return {m_chan(cr, 0), m_chan(cr, 1), m_chan(cr, 2)};
  endfunction

  // Expected {de_out, r, g, b} for a pixel, straight from the VRAM image.
  function automatic logic [24:0] model_pix(input int hh, input int vv, input logic de,
                                            input logic [7:0] mk, input logic [8*NPL-1:0] pl,
                                            input logic [7:0] cm, input logic [7:0] bc);
    int x, y, a, b;
    logic [7:0] cf, cb, rf, rb;
    logic [23:0] fg, bg;
    x = hh - BX;
    y = vv - BY;
    cf = 8'h00;
    cb = 8'h00;
    if (!de) return 25'd0;
    if (x < 0 || x >= HA || y < 0 || y >= VA) return {1'b1, m_rgb(bc)};
    a = (VB + y * ST + x / 8) % 8192;
    b = x % 8;
    for (int i = 0; i < NPL; i++) begin
      if (mk[i] && mem[i][a][b]) begin
        if (i < P) cf = cf | pl[8*i +: 8];
        else       cb = cb | pl[8*i +: 8];
      end
    end
    rf = ((cf & cm) != 8'h00) ? (cf & cm) : cf;
    rb = ((cb & cm) != 8'h00) ? (cb & cm) : cb;
    fg = m_rgb(rf);
    bg = m_rgb(rb);
    if (fg[23:16] != 8'h00) return {1'b1, fg};
    if (bg[23:16] != 8'h00) return {1'b1, bg};
    return {1'b1, m_rgb(bc)};
  endfunction

  task automatic pixel(input int hh, input int vv, input logic de, input int gap, input string tag);
    logic [24:0] want;
    @(negedge clk_sys);
    h = 9'(hh);
    v = 9'(vv);
    de_in  = de;
    ce_pix = 1'b1;
    want = model_pix(hh, vv, de, mask, pal, cmask, bgc);
    @(negedge clk_sys);
    ce_pix = 1'b0;
    check(tag, {7'd0, de_out, red, green, blue}, {7'd0, want});
    repeat (gap) @(negedge clk_sys);
  endtask

  task automatic rand_cfg();
    mask  = ($urandom_range(3) == 0) ? 8'hff : 8'($urandom);
    pal   = 48'({$urandom(), $urandom()});
    cmask = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom);
    bgc   = 8'($urandom);
  endtask

  task automatic run_line(input int vv, input bit directed);
    int r0, yy, want_rd, k;
    logic de;
    r0 = rd_cnt;
    for (int hh = 0; hh < 240; hh++) begin
      rand_cfg();
      de = (hh >= 8 && hh < 232) && ($urandom_range(15) != 0);
      k = hh - BX;
      if (directed && k >= 0 && k < NDIR) begin
        de    = 1'b1;
        mask  = dir_mask[k];
        pal   = '0;
        pal[7:0]      = dir_fg[k];
        pal[8*P +: 8] = dir_bg[k];
        cmask = dir_cm[k];
        bgc   = dir_bgc[k];
        pixel(hh, vv, de, 1, "dir_model");
        check("dir_const", {8'd0, red, green, blue}, {8'd0, dir_rgb[k]});
      end else begin
        pixel(hh, vv, de, $urandom_range(2), "pix");
      end
    end
    repeat (4) @(negedge clk_sys);
    yy = vv - BY;
    want_rd = (yy >= 0 && yy < VA) ? (HA / 8) * NPL : 0;
    check("rd_count", 32'(rd_cnt - r0), 32'(want_rd));
  endtask

  initial begin
    // mask, fg pal, bg pal, cmask, bgc -> rgb, with every plane bit set
    dir_mask[0] = 8'h3f; dir_fg[0] = 8'h11; dir_bg[0] = 8'h00; dir_cm[0] = 8'h00; dir_bgc[0] = 8'h00; dir_rgb[0] = 24'hff0000;
    dir_mask[1] = 8'h3f; dir_fg[1] = 8'h00; dir_bg[1] = 8'h24; dir_cm[1] = 8'h00; dir_bgc[1] = 8'h10; dir_rgb[1] = 24'h7f0000;
    dir_mask[2] = 8'h3f; dir_fg[2] = 8'h10; dir_bg[2] = 8'h24; dir_cm[2] = 8'h00; dir_bgc[2] = 8'h00; dir_rgb[2] = 24'h7f0000;
    dir_mask[3] = 8'h3f; dir_fg[3] = 8'h33; dir_bg[3] = 8'h00; dir_cm[3] = 8'h0f; dir_bgc[3] = 8'h00; dir_rgb[3] = 24'h000000;
    dir_mask[4] = 8'h3f; dir_fg[4] = 8'h33; dir_bg[4] = 8'h00; dir_cm[4] = 8'h40; dir_bgc[4] = 8'h00; dir_rgb[4] = 24'hffff00;
    dir_mask[5] = 8'h00; dir_fg[5] = 8'h11; dir_bg[5] = 8'h24; dir_cm[5] = 8'h00; dir_bgc[5] = 8'h70; dir_rgb[5] = 24'h7f7f7f;
    dir_mask[6] = 8'h3f; dir_fg[6] = 8'h24; dir_bg[6] = 8'h11; dir_cm[6] = 8'h00; dir_bgc[6] = 8'h00; dir_rgb[6] = 24'hff0000;

    for (int p = 0; p < NPL; p++)
      for (int a = 0; a < 8192; a++) mem[p][a] = 8'($urandom);
    for (int p = 0; p < NPL; p++) mem[p][VB + 1 * ST] = 8'hff;

    // Reset held with pixels clocking through the active window.
    de_in = 1'b1;
    mask  = 8'hff;
    pal   = '1;
    bgc   = 8'h77;
    v     = 9'(BY + 2);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk_sys);
      h = 9'(BX - 8 + i);
      ce_pix = ~ce_pix;
      check("rst_rd", {31'd0, vram_rd}, 32'd0);
    end
    ce_pix = 1'b0;
    check("rst_rgb", {7'd0, de_out, red, green, blue}, 32'd0);
    check("rst_addr", {16'd0, vram_plane, vram_addr}, 32'd0);
    check("rst_urun", {31'd0, underrun}, 32'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;

    run_line(BY - 1, 1'b0);
    run_line(BY, 1'b0);
    run_line(BY + 1, 1'b1);
    run_line(BY + 2, 1'b0);
    run_line(BY + 100, 1'b0);
    run_line(BY + VA - 1, 1'b0);
    run_line(BY + VA, 1'b0);
    check("urun_none", {31'd0, underrun}, 32'd0);

    // Reset in the middle of a fetch must drop the strobe without a clock edge.
    rand_cfg();
    pixel(BX - 8, BY + 3, 1'b1, 0, "abort_pix");
    check("abort_rd_pre", {31'd0, vram_rd}, 32'd1);
    #2 reset_n = 1'b0;
    #1 check("abort_rd", {31'd0, vram_rd}, 32'd0);
    check("abort_plane", {29'd0, vram_plane}, 32'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;

    // Pixel clock at full clk_sys rate cannot keep up with a 7-cycle fetch.
    v = 9'(BY + 4);
    de_in = 1'b1;
    for (int hh = BX - 16; hh < BX + 16; hh++) begin
      h = 9'(hh);
      ce_pix = 1'b1;
      @(negedge clk_sys);
      if (hh == BX - 2) check("urun_before", {31'd0, underrun}, 32'd0);
      if (hh == BX - 1) check("urun_set", {31'd0, underrun}, 32'd1);
    end
    ce_pix = 1'b0;
    repeat (10) @(negedge clk_sys);
    check("urun_sticky", {31'd0, underrun}, 32'd1);
    reset_n = 1'b0;
    #1 check("urun_clear", {31'd0, underrun}, 32'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
